// File: rtl/layer_out_serializer.sv
// Captures one layer's parallel neuron outputs and presents them one word per beat
// over a valid/ready stream, with sticky overflow and partial-strobe error flags.
module layer_out_serializer #(
    parameter int numNeuron = 30,
    parameter int dataWidth = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [numNeuron*dataWidth-1:0] in_data,
    input  logic [numNeuron-1:0]           in_valid,
    output logic [dataWidth-1:0]           out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           busy,
    output logic                           overflow,
    output logic                           sync_err
);

    localparam int CW = $clog2(numNeuron) + 1;
    localparam logic [CW-1:0] LAST = CW'(numNeuron - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [numNeuron*dataWidth-1:0] buf_q, buf_d;
    logic [dataWidth-1:0]           data_q, data_d;
    logic                           ovf_q, ovf_d;
    logic                           serr_q, serr_d;
    logic                           capture, partial, xfer, final_xfer;

    // buf_q holds the words after the one on out_data, shifted down on each
    // transfer, so out_data always equals the captured word at index cnt.
    always_comb begin
        capture    = &in_valid;
        partial    = (|in_valid) && !capture;
        xfer       = (state_q == SEND) && out_ready;
        final_xfer = xfer && (cnt_q == LAST);

        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        serr_d  = serr_q | partial;

        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = SEND;
                    cnt_d   = '0;
                    data_d  = in_data[dataWidth-1:0];
                    buf_d   = in_data >> dataWidth;
                end
            end
            SEND: begin
                if (final_xfer) begin
                    cnt_d = '0;
                    if (capture) begin
                        data_d = in_data[dataWidth-1:0];
                        buf_d  = in_data >> dataWidth;
                    end else begin
                        state_d = IDLE;
                        data_d  = '0;
                    end
                end else begin
                    if (xfer) begin
                        cnt_d  = cnt_q + 1'b1;
                        data_d = buf_q[dataWidth-1:0];
                        buf_d  = buf_q >> dataWidth;
                    end
                    if (capture) begin
                        ovf_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            serr_q  <= serr_d;
        end
    end

    assign out_valid = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign out_last  = (state_q == SEND) && (cnt_q == LAST);
    assign out_data  = data_q;
    assign overflow  = ovf_q;
    assign sync_err  = serr_q;

endmodule

// File: tb/tb_layer_out_serializer.sv
// Bench for layer_out_serializer: directed scenarios plus randomized traffic
// compared every cycle against an index-based behavioural model.
module tb_layer_out_serializer;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [W-1:0]   out_data;
    logic           out_valid, out_ready, out_last, busy, overflow, sync_err;

    logic [W-1:0]   in1_data;
    logic [0:0]     in1_valid;
    logic [W-1:0]   out1_data;
    logic           out1_valid, out1_ready, out1_last, busy1, overflow1, sync_err1;

    always #5 clk = ~clk;

    layer_out_serializer #(.numNeuron(N), .dataWidth(W)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .overflow(overflow), .sync_err(sync_err)
    );

    layer_out_serializer #(.numNeuron(1), .dataWidth(W)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in1_data), .in_valid(in1_valid),
        .out_data(out1_data), .out_valid(out1_valid), .out_ready(out1_ready),
        .out_last(out1_last), .busy(busy1), .overflow(overflow1), .sync_err(sync_err1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: m_pos is the index of the word being presented, -1 when nothing is pending.
    int           m_pos = -1;
    logic [W-1:0] m_vec [N];
    bit           m_ovf = 1'b0;
    bit           m_serr = 1'b0;

    always @(posedge clk) begin
        bit full;
        if (rst) begin
            m_pos  = -1;
            m_ovf  = 1'b0;
            m_serr = 1'b0;
        end else begin
            full = (in_valid == '1);
            if (in_valid != '0 && !full) m_serr = 1'b1;
            if (m_pos >= 0 && out_ready) m_pos = (m_pos == N - 1) ? -1 : m_pos + 1;
            if (full) begin
                if (m_pos < 0) begin
                    for (int k = 0; k < N; k++) m_vec[k] = in_data[k*W +: W];
                    m_pos = 0;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model out_valid", out_valid, m_pos >= 0);
            check("model busy", busy, m_pos >= 0);
            check("model out_last", out_last, m_pos == N - 1);
            if (m_pos >= 0) check("model out_data", out_data, m_vec[m_pos]);
            check("model overflow", overflow, m_ovf);
            check("model sync_err", sync_err, m_serr);
        end
    end

    logic [W-1:0] xlog [$];
    logic [W-1:0] eq [$];

    // Records the beat about to transfer (inputs are settled), then advances one cycle.
    task automatic step();
        if (!rst && out_valid && out_ready) xlog.push_back(out_data);
        @(negedge clk);
        #1;
    endtask

    task automatic capture_step(input logic [W-1:0] a, b, c, d);
        in_data  = {d, c, b, a};
        in_valid = '1;
        step();
        in_valid = '0;
    endtask

    task automatic check_seq(input string name, input logic [W-1:0] exp [$]);
        check({name, " length"}, xlog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < xlog.size(); i++)
            check(name, xlog[i], exp[i]);
    endtask

    task automatic expect_beat(input string name, input logic v, input logic [W-1:0] d, input logic l);
        check({name, " valid"}, out_valid, v);
        if (v) check({name, " data"}, out_data, d);
        check({name, " last"}, out_last, l);
    endtask

    initial begin
        int nv;
        rst = 1'b1; in_data = '0; in_valid = '0; out_ready = 1'b1;
        in1_data = '0; in1_valid = '0; out1_ready = 1'b1;
        repeat (3) step();
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_last", out_last, 0);
        check("reset busy", busy, 0);
        check("reset overflow", overflow, 0);
        check("reset sync_err", sync_err, 0);
        check("reset n1 out_valid", out1_valid, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        step();

        // basic vector, ready held high
        capture_step(16'h1, 16'h2, 16'h3, 16'h4);
        expect_beat("basic beat1", 1, 16'h1, 0); step();
        expect_beat("basic beat2", 1, 16'h2, 0); step();
        expect_beat("basic beat3", 1, 16'h3, 0); step();
        expect_beat("basic beat4", 1, 16'h4, 1); step();
        expect_beat("basic after", 0, 16'h0, 0);
        check("basic busy after", busy, 0);

        // stall on the second beat for three cycles
        xlog.delete(); nv = 0;
        capture_step(16'h1, 16'h2, 16'h3, 16'h4);
        for (int i = 0; i < 10; i++) begin
            out_ready = !(i >= 1 && i <= 3);
            if (out_valid) nv++;
            if (i >= 1 && i <= 4) check("stall hold data", out_data, 16'h2);
            step();
        end
        out_ready = 1'b1;
        check("stall valid cycles", nv, 7);
        eq = '{16'h1, 16'h2, 16'h3, 16'h4};
        check_seq("stall seq", eq);

        // back-to-back capture coincident with final transfer
        xlog.delete(); nv = 0;
        capture_step(16'h1, 16'h2, 16'h3, 16'h4);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                in_data  = {16'hD, 16'hC, 16'hB, 16'hA};
                in_valid = '1;
            end else begin
                in_valid = '0;
            end
            if (out_valid) nv++;
            step();
        end
        check("b2b valid cycles", nv, 8);
        eq = '{16'h1, 16'h2, 16'h3, 16'h4, 16'hA, 16'hB, 16'hC, 16'hD};
        check_seq("b2b seq", eq);
        check("b2b overflow", overflow, 0);

        // capture arriving mid-vector is dropped
        xlog.delete();
        capture_step(16'h1, 16'h2, 16'h3, 16'h4);
        for (int i = 0; i < 10; i++) begin
            if (i == 1) begin
                in_data  = {16'hD, 16'hC, 16'hB, 16'hA};
                in_valid = '1;
            end else begin
                in_valid = '0;
            end
            step();
        end
        eq = '{16'h1, 16'h2, 16'h3, 16'h4};
        check_seq("drop seq", eq);
        check("drop overflow", overflow, 1);

        // partial strobe
        in_valid = 4'b0011;
        step();
        in_valid = '0;
        for (int i = 0; i < 3; i++) begin
            check("partial no valid", out_valid, 0);
            step();
        end
        check("partial sync_err", sync_err, 1);
        check("partial overflow sticky", overflow, 1);
        xlog.delete();
        capture_step(16'h11, 16'h22, 16'h33, 16'h44);
        repeat (6) step();
        eq = '{16'h11, 16'h22, 16'h33, 16'h44};
        check_seq("after partial seq", eq);

        // reset mid-vector, with a capture offered during reset
        capture_step(16'h1, 16'h2, 16'h3, 16'h4);
        step(); step();
        check("pre-rst beat3", out_data, 16'h3);
        rst = 1'b1; in_valid = '1;
        step();
        rst = 1'b0; in_valid = '0;
        check("rst abort valid", out_valid, 0);
        check("rst abort overflow", overflow, 0);
        check("rst abort sync_err", sync_err, 0);
        check("rst abort data", out_data, 0);
        step();
        check("rst capture ignored", out_valid, 0);
        xlog.delete();
        capture_step(16'h5, 16'h6, 16'h7, 16'h8);
        repeat (6) step();
        eq = '{16'h5, 16'h6, 16'h7, 16'h8};
        check_seq("restart seq", eq);

        // single-neuron instance
        in1_data = 16'hBEEF; in1_valid = 1'b1;
        step();
        in1_valid = 1'b0;
        check("n1 valid", out1_valid, 1);
        check("n1 data", out1_data, 16'hBEEF);
        check("n1 last", out1_last, 1);
        in1_data = 16'hC0DE; in1_valid = 1'b1;
        step();
        in1_valid = 1'b0;
        check("n1 b2b valid", out1_valid, 1);
        check("n1 b2b data", out1_data, 16'hC0DE);
        check("n1 b2b overflow", overflow1, 0);
        step();
        check("n1 idle", out1_valid, 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 15)      in_valid = '1;
            else if (r < 17) in_valid = N'($urandom_range(1, 14));
            else             in_valid = '0;
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; in_valid = '0; out_ready = 1'b1;
        repeat (8) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_out_serializer.md
LAYER_OUT_SERIALIZER -- requirements
Module: layer_out_serializer

Interface
REQ-001 Parameter numNeuron, default 30, number of neuron outputs captured per layer.
REQ-002 Parameter dataWidth, default 16, width of one neuron output word.
REQ-003 clk  input  1  clock; all logic rising-edge triggered.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  numNeuron*dataWidth  packed neuron outputs; neuron k at bits [k*dataWidth +: dataWidth].
REQ-006 in_valid  input  numNeuron  per-neuron output-valid strobes, one bit per neuron.
REQ-007 out_data  output  dataWidth  serial word presented to the next layer's myinput.
REQ-008 out_valid  output  1  out_data is valid; drives the next layer's myinputValid.
REQ-009 out_ready  input  1  downstream accepts the word; tied high when the consumer has no backpressure.
REQ-010 out_last  output  1  asserted with the beat carrying neuron numNeuron-1.
REQ-011 busy  output  1  high while a captured vector is not fully sent.
REQ-012 overflow  output  1  sticky flag; a vector was dropped.
REQ-013 sync_err  output  1  sticky flag; in_valid was partially asserted.

Function
REQ-014 The block SHALL implement two states, IDLE and SEND; reset state is IDLE.
REQ-015 A capture event SHALL be defined as a cycle with all in_valid bits high.
REQ-016 A cycle with in_valid nonzero but not all ones SHALL set sync_err; no capture occurs.
REQ-017 In IDLE, a capture event SHALL load all of in_data into an internal buffer, clear the beat counter to 0, and move to SEND.
REQ-018 Latency: out_valid SHALL rise in the cycle after the capture event, with out_data = neuron 0.
REQ-019 In SEND, out_valid SHALL be high and out_data SHALL equal buffer word [cnt]; out_data and out_valid SHALL come from registers.
REQ-020 A beat SHALL transfer only when out_valid and out_ready are both high; otherwise out_data, out_last and cnt hold.
REQ-021 On a transfer with cnt < numNeuron-1, cnt SHALL increment by 1 and the next word SHALL be presented in the next cycle.
REQ-022 out_last SHALL be high exactly when out_valid is high and cnt == numNeuron-1.
REQ-023 On the transfer with cnt == numNeuron-1, the block SHALL return to IDLE with out_valid low, unless REQ-024 applies.
REQ-024 A capture event in the same cycle as the final transfer SHALL be accepted: buffer reloaded, cnt = 0, state stays SEND, with no bubble between vectors.
REQ-025 A capture event in SEND other than under REQ-024 SHALL be discarded and SHALL set overflow; the vector in flight SHALL be unaffected.
REQ-026 With out_ready held high, a vector SHALL occupy exactly numNeuron consecutive out_valid cycles.
REQ-027 busy SHALL equal (state == SEND).
REQ-028 cnt SHALL be $clog2(numNeuron)+1 bits wide and SHALL never exceed numNeuron-1.
REQ-029 numNeuron = 1 SHALL be supported: a single beat with out_last high.
REQ-030 The words SHALL be passed through unmodified, with no sign handling or arithmetic.

Reset
REQ-031 While rst is high, state SHALL be IDLE, cnt 0, and out_valid, out_last, busy, overflow and sync_err 0; out_data SHALL be 0.
REQ-032 Reset asserted mid-vector SHALL abort the vector; no further beats are sent, and the remaining words are lost.
REQ-033 A capture event in the cycle rst is high SHALL be ignored.
REQ-034 overflow and sync_err SHALL clear only on rst.

Verification
REQ-035 numNeuron=4, out_ready=1, capture words 0x0001,0x0002,0x0003,0x0004 at cycle T -> out_valid high for cycles T+1 to T+4 with data 1,2,3,4; out_last only at T+4; busy low at T+5.
REQ-036 Same vector, with out_ready low on the 2nd beat for 3 cycles -> word 0x0002 held stable for 4 cycles; total 7 valid cycles; sequence unchanged.
REQ-037 Second capture (0x0A..0x0D) coincident with the final transfer of the first vector -> 8 consecutive beats 1,2,3,4,A,B,C,D; overflow stays 0.
REQ-038 Second capture arriving at the 2nd beat -> first vector completes intact; second vector is never emitted; overflow=1 until rst.
REQ-039 in_valid=4'b0011 for one cycle -> no out_valid; sync_err=1; a later all-ones capture still serializes normally.
REQ-040 rst pulsed at the 3rd beat -> out_valid low the next cycle; flags 0; a fresh capture restarts from neuron 0.
